// File: rtl/hb_period_meas.sv
// rtl/hb_period_meas.sv - heartbeat period meter with averaging, timeout and reciprocal-stage handshake
//
// Measures the period of an asynchronous heartbeat in clk cycles, averages
// 2^AVG_LOG2 samples, and publishes the result as unsigned-valued signed QF.
// Each result is handed to a downstream reciprocal stage via start_calc/calc_done.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   enable     - measurement runs while high
//   hb_in      - asynchronous heartbeat input
//   start_calc - one-cycle request to downstream stage
//   calc_done  - downstream completion pulse
//   x_out      - averaged period, QF (F fractional bits), saturated, never negative
//   timeout    - sticky no-heartbeat flag (x_out = 0 when set)
//   ovr_cnt    - saturating count of samples dropped while waiting on downstream
//
// Build option: define HB_OVERRUN_CNT_EN to build the overrun counter;
// otherwise ovr_cnt is tied to zero.
module hb_period_meas #(
  parameter int W           = 32,
  parameter int F           = 16,
  parameter int CNT_W       = 24,
  parameter int AVG_LOG2    = 2,
  parameter int SCALE_LOG2  = 0,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         hb_in,
  output logic         start_calc,
  input  logic         calc_done,
  output logic [W-1:0] x_out,
  output logic         timeout,
  output logic [7:0]   ovr_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_MEAS = 3'd2;
  localparam logic [2:0] S_REQ  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  localparam int SW = CNT_W + AVG_LOG2;
  localparam int IW = AVG_LOG2 + 1;
  localparam int XW = SW + F;
  // Result is formed wide enough that neither the shift nor the saturation
  // compare can lose bits, whatever W is.
  localparam int PW = (XW > W) ? XW : W;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT_CYC);
  localparam logic [IW-1:0]    LAST_IDX = IW'((1 << AVG_LOG2) - 1);
  localparam logic [PW-1:0]    X_MAX    = PW'({1'b0, {(W-1){1'b1}}});

  logic [2:0]       state;
  logic             hb_s1, hb_s2, hb_s3, hb_rise;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    sum;
  logic [IW-1:0]    idx;

  logic [CNT_W-1:0] cnt_inc;
  logic [SW-1:0]    sum_total;
  logic [PW-1:0]    x_full;
  logic [W-1:0]     x_sat;
  logic             timeout_hit;

  // cnt_inc doubles as the sample value: cnt+1 saturated equals the period.
  assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign sum_total   = sum + SW'(cnt_inc);
  assign x_full      = (PW'(sum_total) << F) >> (AVG_LOG2 + SCALE_LOG2);
  assign x_sat       = (x_full > X_MAX) ? X_MAX[W-1:0] : x_full[W-1:0];
  assign timeout_hit = (cnt >= TO_CNT);

  // Combinational on enable so that dropping enable while in S_REQ
  // suppresses the request in that very cycle.
  assign start_calc = (state == S_REQ) && enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      hb_s1   <= 1'b0;
      hb_s2   <= 1'b0;
      hb_s3   <= 1'b0;
      hb_rise <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      idx     <= '0;
      x_out   <= '0;
      timeout <= 1'b0;
    end else begin
      hb_s1   <= hb_in;
      hb_s2   <= hb_s1;
      hb_s3   <= hb_s2;
      hb_rise <= hb_s2 & ~hb_s3;

      case (state)
        S_IDLE: begin
          if (enable) begin
            cnt     <= '0;
            sum     <= '0;
            idx     <= '0;
            timeout <= 1'b0;
            state   <= S_ARM;
          end
        end

        S_ARM, S_MEAS: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (hb_rise) begin
            // A heartbeat beats a coincident timeout.
            cnt <= '0;
            if (state == S_ARM) begin
              state <= S_MEAS;
            end else if (idx == LAST_IDX) begin
              x_out <= x_sat;
              state <= S_REQ;
            end else begin
              sum <= sum_total;
              idx <= idx + 1'b1;
            end
          end else if (timeout_hit) begin
            timeout <= 1'b1;
            x_out   <= '0;
            state   <= S_REQ;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_REQ: begin
          // An edge landing here restarts the period but its sample is lost.
          if (hb_rise) cnt <= '0;
          if (!enable) begin
            state <= S_IDLE;
          end else begin
            sum   <= '0;
            idx   <= '0;
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          // enable is deliberately ignored until the downstream answers.
          cnt <= hb_rise ? '0 : cnt_inc;
          if (calc_done) state <= enable ? S_MEAS : S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HB_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt <= 8'd0;
    end else if ((state == S_WAIT) && hb_rise && (ovr_cnt != 8'hFF)) begin
      ovr_cnt <= ovr_cnt + 8'd1;
    end
  end
`else
  assign ovr_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_hb_period_meas.sv
// tb/tb_hb_period_meas.sv - scoreboard bench for hb_period_meas
module tb_hb_period_meas;

  typedef int iq_t[$];
  typedef struct {
    logic [31:0] x;
    logic        t;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n[3];
  logic        enable[3];
  logic        hb[3];
  logic        calc_done[3];
  logic        sc[3];
  logic        to[3];
  logic [31:0] xo[3];
  logic [7:0]  oc[3];

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        q0[$], q1[$], q2[$];
  int          done_dly[3];
  int          rst_gen[3];
  int          done_seen[3] = '{0, 0, 0};
  int          pulse_seen[3] = '{0, 0, 0};
  bit          waiting[3] = '{0, 0, 0};
  logic [31:0] held[3];
  bit          c_done;

  hb_period_meas dut_a (
    .clk(clk), .rst_n(rst_n[0]), .enable(enable[0]), .hb_in(hb[0]),
    .start_calc(sc[0]), .calc_done(calc_done[0]), .x_out(xo[0]),
    .timeout(to[0]), .ovr_cnt(oc[0]));

  hb_period_meas #(.SCALE_LOG2(2), .TIMEOUT_CYC(1000)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .enable(enable[1]), .hb_in(hb[1]),
    .start_calc(sc[1]), .calc_done(calc_done[1]), .x_out(xo[1]),
    .timeout(to[1]), .ovr_cnt(oc[1]));

  hb_period_meas #(.AVG_LOG2(0)) dut_c (
    .clk(clk), .rst_n(rst_n[2]), .enable(enable[2]), .hb_in(hb[2]),
    .start_calc(sc[2]), .calc_done(calc_done[2]), .x_out(xo[2]),
    .timeout(to[2]), .ovr_cnt(oc[2]));

  task automatic check(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: mean period in QF, scaled by 2^-SCALE_LOG2, clipped to int max.
  function automatic longint model_x(iq_t per, int alog, int slog);
    longint v = 0;
    foreach (per[k]) v += per[k];
    v = (v << 16) >> (alog + slog);
    if (v > 64'h7FFF_FFFF) v = 64'h7FFF_FFFF;
    return v;
  endfunction

  function automatic iq_t rep(int p, int n);
    iq_t q;
    for (int k = 0; k < n; k++) q.push_back(p);
    return q;
  endfunction

  function automatic void push_exp(int i, exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic bit pop_exp(int i, output exp_t e);
    e.x = '0;
    e.t = 1'b0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  // Monitor: every request must match the head of that DUT's queue, and
  // x_out must still hold the requested value when calc_done arrives.
  task automatic mon(int i);
    exp_t e;
    bit   ok;
    if (!rst_n[i]) waiting[i] = 1'b0;
    if (sc[i]) begin
      pulse_seen[i]++;
      ok = pop_exp(i, e);
      check($sformatf("dut%0d_req_expected", i), longint'(ok), 1);
      if (ok) begin
        check($sformatf("dut%0d_x_out", i), longint'(xo[i]), longint'(e.x));
        check($sformatf("dut%0d_timeout", i), longint'(to[i]), longint'(e.t));
      end
      waiting[i] = 1'b1;
      held[i]    = xo[i];
    end else if (calc_done[i] && waiting[i]) begin
      check($sformatf("dut%0d_x_stable", i), longint'(xo[i]), longint'(held[i]));
      waiting[i] = 1'b0;
      done_seen[i]++;
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0);
    mon(1);
    mon(2);
  end

  // Downstream stand-in: answers each request after done_dly cycles unless
  // the DUT was reset in the meantime.
  task automatic resp(int i);
    int g;
    forever begin
      @(posedge clk);
      #2;
      if (sc[i]) begin
        g = rst_gen[i];
        for (int k = 0; k < done_dly[i]; k++) @(negedge clk);
        if (g == rst_gen[i]) begin
          calc_done[i] = 1'b1;
          @(negedge clk);
          calc_done[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic pulse(int i);
    hb[i] = 1'b1;
    repeat (3) @(negedge clk);
    hb[i] = 1'b0;
  endtask

  // Arm edge after gap cycles, then one rising edge per listed period.
  task automatic send(int i, int gap, iq_t per);
    repeat (gap) @(negedge clk);
    pulse(i);
    foreach (per[k]) begin
      repeat (per[k] - 3) @(negedge clk);
      pulse(i);
    end
  endtask

  task automatic wait_done(int i, int old);
    int b = 0;
    while (done_seen[i] == old && b < 5000) begin
      @(negedge clk);
      b++;
    end
    check($sformatf("dut%0d_handshake_done", i), longint'(done_seen[i] != old), 1);
  endtask

  task automatic run(int i, int gap, iq_t per, int alog, int slog, int dly);
    exp_t e;
    int   old;
    done_dly[i] = dly;
    enable[i]   = 1'b1;
    e.x = 32'(model_x(per, alog, slog));
    e.t = 1'b0;
    push_exp(i, e);
    old = done_seen[i];
    send(i, gap, per);
    wait_done(i, old);
    enable[i] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    iq_t  per;
    exp_t e;
    int   old, b;
    int   exp_ov;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; enable[i] = 1'b0; hb[i] = 1'b0;
      calc_done[i] = 1'b0; done_dly[i] = 2; rst_gen[i] = 0;
    end
    c_done = 1'b0;
    fork resp(0); resp(1); resp(2); join_none
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dut%0d_rst_x_out", i), longint'(xo[i]), 0);
      check($sformatf("dut%0d_rst_timeout", i), longint'(to[i]), 0);
      check($sformatf("dut%0d_rst_start_calc", i), longint'(sc[i]), 0);
      check($sformatf("dut%0d_rst_ovr_cnt", i), longint'(oc[i]), 0);
    end
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);

    // Single-sample build: saturation and a plain period, in parallel.
    fork
      begin
        run(2, 5, rep(40000, 1), 0, 0, 5);
        run(2, 5, rep(100, 1), 0, 0, 3);
        c_done = 1'b1;
      end
    join_none

    // Defaults: basic average, mixed periods, random periods.
    run(0, 5, rep(100, 4), 2, 0, 2);
    per = {90, 110, 100, 100};
    run(0, 5, per, 2, 0, 4);
    repeat (6) begin
      per = {};
      repeat (4) per.push_back(int'($urandom_range(300, 8)));
      run(0, int'($urandom_range(20, 2)), per, 2, 0, int'($urandom_range(40, 2)));
    end

    // Overrun: downstream stalls 550 cycles while edges keep coming.
`ifdef HB_OVERRUN_CNT_EN
    exp_ov = 5;
`else
    exp_ov = 0;
`endif
    done_dly[0] = 550;
    enable[0]   = 1'b1;
    e.x = 32'd6553600;
    e.t = 1'b0;
    push_exp(0, e);
    old = done_seen[0];
    send(0, 5, rep(100, 9));
    wait_done(0, old);
    check("dut0_ovr_cnt", longint'(oc[0]), longint'(exp_ov));
    enable[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while waiting on downstream, then the first edge must only arm.
    done_dly[0] = 300;
    enable[0]   = 1'b1;
    push_exp(0, e);
    old = pulse_seen[0];
    send(0, 5, rep(100, 4));
    b = 0;
    while (pulse_seen[0] == old && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check("dut0_req_before_reset", longint'(pulse_seen[0] != old), 1);
    repeat (20) @(negedge clk);
    rst_gen[0]++;
    rst_n[0] = 1'b0;
    #1;
    check("dut0_midwait_rst_x_out", longint'(xo[0]), 0);
    check("dut0_midwait_rst_timeout", longint'(to[0]), 0);
    check("dut0_midwait_rst_start_calc", longint'(sc[0]), 0);
    check("dut0_midwait_rst_ovr_cnt", longint'(oc[0]), 0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    run(0, 300, rep(100, 4), 2, 0, 2);

    // Scaled build with a 1000-cycle timeout.
    run(1, 5, rep(100, 4), 2, 2, 2);
    run(1, 5, rep(1001, 4), 2, 2, 3);
    done_dly[1] = 4;
    enable[1]   = 1'b1;
    e.x = 32'd0;
    e.t = 1'b1;
    push_exp(1, e);
    old = done_seen[1];
    repeat (5) @(negedge clk);
    pulse(1);
    wait_done(1, old);
    enable[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("dut1_timeout_sticky", longint'(to[1]), 1);
    enable[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("dut1_timeout_cleared", longint'(to[1]), 0);
    enable[1] = 1'b0;
    repeat (3) @(negedge clk);
    repeat (3) begin
      per = {};
      repeat (4) per.push_back(int'($urandom_range(900, 8)));
      run(1, 5, per, 2, 2, int'($urandom_range(30, 2)));
    end

    b = 0;
    while (!c_done && b < 100000) begin
      @(negedge clk);
      b++;
    end
    check("dut2_sequence_done", longint'(c_done), 1);
    check("dut0_queue_empty", longint'(q0.size()), 0);
    check("dut1_queue_empty", longint'(q1.size()), 0);
    check("dut2_queue_empty", longint'(q2.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
